// File: rtl/xcore_if_bpu_pkg.sv
// Shared definitions for the fetch-stage branch predictor.
//   WIDTH          default PC width
//   *_DEPTH_DEF    default BHT / BTB sizes
//   cnt2_t         2-bit saturating direction counter
//   CNT_*          counter encodings and reset value (weak not-taken)
//   sat_inc16      saturating 16-bit increment for statistics counters
package xcore_if_bpu_pkg;

  localparam int WIDTH         = 32;
  localparam int BHT_DEPTH_DEF = 16;
  localparam int BTB_DEPTH_DEF = 8;

  typedef logic [1:0] cnt2_t;

  localparam cnt2_t CNT_SNT = 2'b00;
  localparam cnt2_t CNT_WNT = 2'b01;
  localparam cnt2_t CNT_WT  = 2'b10;
  localparam cnt2_t CNT_ST  = 2'b11;
  localparam cnt2_t CNT_RST = CNT_WNT;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/xcore_bpu_cnt2.sv
// 2-bit saturating counter next-state logic (combinational).
//   i_cnt    current counter value
//   i_taken  resolved direction: 1 = count up, 0 = count down
//   o_cnt    next counter value, clamped at strong-NT / strong-T
module xcore_bpu_cnt2
  import xcore_if_bpu_pkg::*;
(
  input  cnt2_t i_cnt,
  input  logic  i_taken,
  output cnt2_t o_cnt
);

  always_comb begin
    o_cnt = i_cnt;
    if (i_taken) begin
      if (i_cnt != CNT_ST) o_cnt = i_cnt + 2'd1;
    end else begin
      if (i_cnt != CNT_SNT) o_cnt = i_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/xcore_if_bpu.sv
// Fetch-stage branch predictor: bimodal BHT of 2-bit counters plus a
// direct-mapped BTB. Lookup is purely combinational on the fetch PC;
// training comes from the memory-stage resolver one branch at a time.
//   i_clk, i_rst                 clock, async active-high reset
//   i_if_pc, i_if_valid          fetch lookup request
//   o_bpu_deci                   2'b00 = not-taken, else taken counter value
//   o_bpu_taken, o_bpu_target    redirect decision and next fetch PC
//   i_upd_*                      resolved-branch training strobe and data
//   o_mispred_cnt                saturating mispredict statistic
module xcore_if_bpu
  import xcore_if_bpu_pkg::*;
#(
  parameter int BHT_DEPTH = BHT_DEPTH_DEF,
  parameter int BTB_DEPTH = BTB_DEPTH_DEF,
  parameter int PC_W      = WIDTH
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [PC_W-1:0] i_if_pc,
  input  logic            i_if_valid,
  output logic [1:0]      o_bpu_deci,
  output logic            o_bpu_taken,
  output logic [PC_W-1:0] o_bpu_target,
  input  logic            i_upd_valid,
  input  logic [PC_W-1:0] i_upd_pc,
  input  logic            i_upd_taken,
  input  logic [PC_W-1:0] i_upd_target,
  input  logic            i_upd_mispred,
  output logic [15:0]     o_mispred_cnt
);

  localparam int BHT_AW = $clog2(BHT_DEPTH);
  localparam int BTB_AW = $clog2(BTB_DEPTH);
  localparam int TAG_W  = PC_W - BTB_AW - 2;

  // State
  cnt2_t                 bht_q     [BHT_DEPTH];
  cnt2_t                 bht_d     [BHT_DEPTH];
  logic [BTB_DEPTH-1:0]  btb_vld_q;
  logic [BTB_DEPTH-1:0]  btb_vld_d;
  logic [TAG_W-1:0]      btb_tag_q [BTB_DEPTH];
  logic [TAG_W-1:0]      btb_tag_d [BTB_DEPTH];
  logic [PC_W-1:0]       btb_tgt_q [BTB_DEPTH];
  logic [PC_W-1:0]       btb_tgt_d [BTB_DEPTH];
  logic [15:0]           mispred_cnt_q;
  logic [15:0]           mispred_cnt_d;

  // Index / tag extraction (PCs are word aligned, bits [1:0] ignored)
  logic [BHT_AW-1:0] lk_bht_idx;
  logic [BTB_AW-1:0] lk_btb_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [BHT_AW-1:0] upd_bht_idx;
  logic [BTB_AW-1:0] upd_btb_idx;
  logic [TAG_W-1:0]  upd_tag;

  assign lk_bht_idx  = i_if_pc[BHT_AW+1:2];
  assign lk_btb_idx  = i_if_pc[BTB_AW+1:2];
  assign lk_tag      = i_if_pc[PC_W-1:BTB_AW+2];
  assign upd_bht_idx = i_upd_pc[BHT_AW+1:2];
  assign upd_btb_idx = i_upd_pc[BTB_AW+1:2];
  assign upd_tag     = i_upd_pc[PC_W-1:BTB_AW+2];

  logic unused_upd_pc_lsb;
  assign unused_upd_pc_lsb = ^i_upd_pc[1:0];

  // Lookup path: reads registered state only, so a same-cycle update to the
  // same entry is not visible until the following cycle.
  cnt2_t           lk_cnt;
  logic            lk_pred;
  logic            lk_hit;
  logic [PC_W-1:0] pc_plus4;

  always_comb begin
    lk_cnt       = bht_q[lk_bht_idx];
    lk_pred      = (lk_cnt >= CNT_WT);
    lk_hit       = btb_vld_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == lk_tag);
    pc_plus4     = i_if_pc + PC_W'(4);
    o_bpu_deci   = CNT_SNT;
    o_bpu_taken  = 1'b0;
    o_bpu_target = pc_plus4;
    if (i_if_valid) begin
      // A taken counter without a BTB hit still reports its value so the
      // resolver knows the direction was predicted taken.
      if (lk_pred) o_bpu_deci = lk_cnt;
      if (lk_pred && lk_hit) begin
        o_bpu_taken  = 1'b1;
        o_bpu_target = btb_tgt_q[lk_btb_idx];
      end
    end
  end

  // Training path
  cnt2_t upd_cnt_cur;
  cnt2_t upd_cnt_nxt;

  assign upd_cnt_cur = bht_q[upd_bht_idx];

  xcore_bpu_cnt2 u_cnt2 (
    .i_cnt   (upd_cnt_cur),
    .i_taken (i_upd_taken),
    .o_cnt   (upd_cnt_nxt)
  );

  always_comb begin
    bht_d         = bht_q;
    btb_vld_d     = btb_vld_q;
    btb_tag_d     = btb_tag_q;
    btb_tgt_d     = btb_tgt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (i_upd_valid) begin
      bht_d[upd_bht_idx] = upd_cnt_nxt;
      // Taken branches always claim their BTB slot; not-taken ones leave it.
      if (i_upd_taken) begin
        btb_vld_d[upd_btb_idx] = 1'b1;
        btb_tag_d[upd_btb_idx] = upd_tag;
        btb_tgt_d[upd_btb_idx] = i_upd_target;
      end
      if (i_upd_mispred) mispred_cnt_d = sat_inc16(mispred_cnt_q);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CNT_RST;
      btb_vld_q     <= '0;
      mispred_cnt_q <= '0;
    end else begin
      bht_q         <= bht_d;
      btb_vld_q     <= btb_vld_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Tag/target payload is qualified by btb_vld_q, so it carries no reset.
  always_ff @(posedge i_clk) begin
    btb_tag_q <= btb_tag_d;
    btb_tgt_q <= btb_tgt_d;
  end

  assign o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_xcore_if_bpu.sv
module tb_xcore_if_bpu;

  localparam int BHT = 16;
  localparam int BTB = 8;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_if_pc;
  logic        i_if_valid;
  logic [1:0]  o_bpu_deci;
  logic        o_bpu_taken;
  logic [31:0] o_bpu_target;
  logic        i_upd_valid;
  logic [31:0] i_upd_pc;
  logic        i_upd_taken;
  logic [31:0] i_upd_target;
  logic        i_upd_mispred;
  logic [15:0] o_mispred_cnt;

  xcore_if_bpu #(.BHT_DEPTH(BHT), .BTB_DEPTH(BTB), .PC_W(32)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_if_pc       (i_if_pc),
    .i_if_valid    (i_if_valid),
    .o_bpu_deci    (o_bpu_deci),
    .o_bpu_taken   (o_bpu_taken),
    .o_bpu_target  (o_bpu_target),
    .i_upd_valid   (i_upd_valid),
    .i_upd_pc      (i_upd_pc),
    .i_upd_taken   (i_upd_taken),
    .i_upd_target  (i_upd_target),
    .i_upd_mispred (i_upd_mispred),
    .o_mispred_cnt (o_mispred_cnt)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: counters as small integers, BTB entries remember the
  // full PC of the branch that last wrote them.
  int          m_cnt [BHT];
  bit          m_vld [BTB];
  logic [31:0] m_pc  [BTB];
  logic [31:0] m_tgt [BTB];
  int          m_mis;

  function automatic void m_reset();
    for (int i = 0; i < BHT; i++) m_cnt[i] = 1;
    for (int i = 0; i < BTB; i++) m_vld[i] = 1'b0;
    m_mis = 0;
  endfunction

  function automatic void m_update(input logic [31:0] pc, input bit taken,
                                   input logic [31:0] tgt, input bit mis);
    int b;
    int t;
    b = int'((pc >> 2) % BHT);
    t = int'((pc >> 2) % BTB);
    if (taken) m_cnt[b] = (m_cnt[b] == 3) ? 3 : m_cnt[b] + 1;
    else       m_cnt[b] = (m_cnt[b] == 0) ? 0 : m_cnt[b] - 1;
    if (taken) begin
      m_vld[t] = 1'b1;
      m_pc[t]  = pc;
      m_tgt[t] = tgt;
    end
    if (mis && m_mis < 65535) m_mis++;
  endfunction

  task automatic check_lookup(input string tag);
    int          c;
    int          t;
    bit          hit;
    logic [31:0] ed;
    logic [31:0] et;
    logic [31:0] etgt;
    c   = m_cnt[int'((i_if_pc >> 2) % BHT)];
    t   = int'((i_if_pc >> 2) % BTB);
    hit = m_vld[t] && ((m_pc[t] >> 2) == (i_if_pc >> 2));
    ed  = (i_if_valid && c >= 2) ? 32'(c) : 32'd0;
    et  = (i_if_valid && c >= 2 && hit) ? 32'd1 : 32'd0;
    etgt = (et == 32'd1) ? m_tgt[t] : i_if_pc + 32'd4;
    check({tag, "_deci"}, 32'(o_bpu_deci), ed);
    check({tag, "_taken"}, 32'(o_bpu_taken), et);
    check({tag, "_target"}, o_bpu_target, etgt);
  endtask

  task automatic drive(input bit ifv, input logic [31:0] ifpc, input bit uv,
                       input logic [31:0] upc, input bit utk,
                       input logic [31:0] utgt, input bit umis);
    i_if_valid    = ifv;
    i_if_pc       = ifpc;
    i_upd_valid   = uv;
    i_upd_pc      = upc;
    i_upd_taken   = utk;
    i_upd_target  = utgt;
    i_upd_mispred = umis;
    #1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    if (i_upd_valid && !i_rst)
      m_update(i_upd_pc, i_upd_taken, i_upd_target, i_upd_mispred);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    m_reset();
  endtask

  logic [31:0] pool [8];

  initial begin
    i_rst = 1'b1;
    i_if_valid = 0; i_if_pc = 0; i_upd_valid = 0; i_upd_pc = 0;
    i_upd_taken = 0; i_upd_target = 0; i_upd_mispred = 0;
    m_reset();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Reset state
    drive(1, 32'h100, 0, 0, 0, 0, 0);
    check("rst_deci", 32'(o_bpu_deci), 32'd0);
    check("rst_taken", 32'(o_bpu_taken), 32'd0);
    check("rst_target", o_bpu_target, 32'h104);
    check("rst_mis", 32'(o_mispred_cnt), 32'd0);
    drive(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    check("wrap_target", o_bpu_target, 32'h0);

    // Train taken twice
    drive(0, 0, 1, 32'h100, 1, 32'h200, 0); tick();
    drive(0, 0, 1, 32'h100, 1, 32'h200, 0); tick();
    drive(1, 32'h100, 0, 0, 0, 0, 0);
    check("t2_deci", 32'(o_bpu_deci), 32'd3);
    check("t2_taken", 32'(o_bpu_taken), 32'd1);
    check("t2_target", o_bpu_target, 32'h200);

    // Four not-taken: saturates at strong not-taken
    repeat (4) begin drive(0, 0, 1, 32'h100, 0, 32'h0, 0); tick(); end
    drive(1, 32'h100, 0, 0, 0, 0, 0);
    check("t3_deci", 32'(o_bpu_deci), 32'd0);
    check("t3_target", o_bpu_target, 32'h104);
    check_lookup("t3_model");

    // Same-cycle update and lookup: no bypass
    do_reset();
    drive(1, 32'h140, 1, 32'h140, 1, 32'h240, 0);
    check("t4_old_deci", 32'(o_bpu_deci), 32'd0);
    check("t4_old_target", o_bpu_target, 32'h144);
    tick();
    drive(1, 32'h140, 0, 0, 0, 0, 0);
    check("t4_new_deci", 32'(o_bpu_deci), 32'd2);
    check("t4_new_taken", 32'(o_bpu_taken), 32'd1);
    check("t4_new_target", o_bpu_target, 32'h240);

    // BTB alias: 0x100 and 0x120 share a BTB slot, not a BHT counter
    do_reset();
    repeat (2) begin drive(0, 0, 1, 32'h100, 1, 32'h300, 0); tick(); end
    repeat (2) begin drive(0, 0, 1, 32'h120, 1, 32'h400, 0); tick(); end
    drive(1, 32'h100, 0, 0, 0, 0, 0);
    check("t5_deci", 32'(o_bpu_deci), 32'd3);
    check("t5_taken", 32'(o_bpu_taken), 32'd0);
    check("t5_target", o_bpu_target, 32'h104);
    drive(1, 32'h120, 0, 0, 0, 0, 0);
    check("t5b_taken", 32'(o_bpu_taken), 32'd1);
    check("t5b_target", o_bpu_target, 32'h400);
    drive(0, 32'h120, 0, 0, 0, 0, 0);
    check("t5c_deci", 32'(o_bpu_deci), 32'd0);
    check("t5c_taken", 32'(o_bpu_taken), 32'd0);

    // Randomized traffic against the model
    pool[0] = 32'h100;       pool[1] = 32'h120;       pool[2] = 32'h140;
    pool[3] = 32'h180;       pool[4] = 32'h1000_0100; pool[5] = 32'hFFFF_FFFC;
    pool[6] = 32'h8000_0120; pool[7] = 32'h3C;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] lpc;
      logic [31:0] upc;
      lpc = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h3FC) : pool[$urandom_range(0, 7)];
      upc = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h3FC) : pool[$urandom_range(0, 7)];
      drive($urandom_range(0, 3) != 0, lpc, $urandom_range(0, 1) == 1, upc,
            $urandom_range(0, 2) != 0, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 3) == 0);
      check_lookup("rnd");
      check("rnd_mis", 32'(o_mispred_cnt), 32'(m_mis));
      tick();
    end

    // Async reset in the middle of a mispredict update
    drive(1, 32'h100, 1, 32'h100, 1, 32'h500, 1);
    #2;
    i_rst = 1'b1;
    #1;
    m_reset();
    check("arst_mis", 32'(o_mispred_cnt), 32'd0);
    check("arst_deci", 32'(o_bpu_deci), 32'd0);
    check("arst_target", o_bpu_target, 32'h104);
    tick();
    check("arst_hold_mis", 32'(o_mispred_cnt), 32'd0);
    i_rst = 1'b0;
    drive(1, 32'h100, 0, 0, 0, 0, 0);
    check_lookup("arst_post");

    // Mispredict counter saturation
    drive(0, 0, 1, 32'h500, 1, 32'h500, 1);
    repeat (65534) tick();
    check("sat_fffe", 32'(o_mispred_cnt), 32'hFFFE);
    repeat (6) tick();
    check("sat_ffff", 32'(o_mispred_cnt), 32'hFFFF);
    check("sat_model", 32'(o_mispred_cnt), 32'(m_mis));
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
